// File: rtl/handshake_transmitter_pkg.sv
// Shared link constants and the transmitter state type.
// SYNCWORD must be non-zero so the idle-low line can never look like a sync pattern.
package NetworkPkg;
  localparam int SYNC_BITS     = 8;
  localparam int ENC_HEAD_BITS = 16;
  localparam int FRAME_BITS    = SYNC_BITS + ENC_HEAD_BITS;

  localparam logic [SYNC_BITS-1:0] SYNCWORD = 8'hB4;

  // Terminal counts for the 8-bit per-state bit counter.
  localparam logic [7:0] SYNC_LAST = 8'(SYNC_BITS - 1);
  localparam logic [7:0] DATA_LAST = 8'(ENC_HEAD_BITS - 1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, DONE} tx_state_t;
endpackage

// File: rtl/handshake_transmitter_counter.sv
// Up-counter with synchronous clear (priority) and count enable.
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      r_count <= '0;
    else if (i_clear)
      r_count <= '0;
    else if (i_enable)
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
endmodule

// File: rtl/handshake_transmitter_shift_reg.sv
// Left-shifting frame register with parallel load (load wins over shift).
// o_msbNext is the MSB the register will hold after this edge.
module shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_serialIn,
  output logic             o_msbNext
);
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = r_q;
    if (i_load)
      w_next = i_d;
    else if (i_shift)
      w_next = {r_q[WIDTH-2:0], i_serialIn};
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      r_q <= '0;
    else
      r_q <= w_next;
  end

  // Exposing the post-edge MSB lets the owner register the bit with one cycle of latency.
  assign o_msbNext = w_next[WIDTH-1];
endmodule

// File: rtl/handshake_transmitter.sv
// Serialises SYNCWORD followed by the encoded packet, MSB first, onto the handshake wire.
// send_start in any state aborts the current frame and restarts from the freshly sampled data_in.
module handshake_transmitter
  import NetworkPkg::*;
(
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     send_start,
  input  logic [ENC_HEAD_BITS-1:0] data_in,
  output logic                     serial_out,
  output logic                     send_done,
  output logic                     sending
);
  tx_state_t             r_state;
  logic                  r_serial;
  logic                  r_done;
  logic                  r_sending;
  logic [7:0]            w_count;
  logic                  w_msbNext;
  logic                  w_active;
  logic                  w_lastSync;
  logic                  w_lastData;
  logic [FRAME_BITS-1:0] w_loadValue;

  assign w_loadValue = {SYNCWORD, data_in};
  assign w_active    = (r_state == SYNC) || (r_state == DATA);
  assign w_lastSync  = (r_state == SYNC) && (w_count == SYNC_LAST);
  assign w_lastData  = (r_state == DATA) && (w_count == DATA_LAST);

  shift_reg #(.WIDTH(FRAME_BITS)) u_frame (
    .clk        (clk),
    .rst_l      (rst_l),
    .i_load     (send_start),
    .i_shift    (w_active),
    .i_d        (w_loadValue),
    .i_serialIn (1'b0),
    .o_msbNext  (w_msbNext)
  );

  // The counter restarts at every state entry, so it only ever counts up to the current phase length.
  counter #(.WIDTH(8)) u_bitCount (
    .clk      (clk),
    .rst_l    (rst_l),
    .i_clear  (send_start || w_lastSync || w_lastData),
    .i_enable (w_active),
    .o_count  (w_count)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state   <= IDLE;
      r_serial  <= 1'b0;
      r_done    <= 1'b0;
      r_sending <= 1'b0;
    end else if (send_start) begin
      r_state   <= SYNC;
      r_serial  <= w_msbNext;
      r_done    <= 1'b0;
      r_sending <= 1'b1;
    end else begin
      case (r_state)
        SYNC: begin
          r_serial <= w_msbNext;
          if (w_lastSync)
            r_state <= DATA;
        end
        DATA: begin
          if (w_lastData) begin
            r_state   <= DONE;
            r_serial  <= 1'b0;
            r_done    <= 1'b1;
            r_sending <= 1'b0;
          end else begin
            r_serial <= w_msbNext;
          end
        end
        default: r_serial <= 1'b0;
      endcase
    end
  end

  assign serial_out = r_serial;
  assign send_done  = r_done;
  assign sending    = r_sending;
endmodule

// File: tb/tb_handshake_transmitter.sv
// Directed bench for handshake_transmitter: 8-bit sync 0xB4 followed by a 16-bit packet, MSB first.
// A bench-side LSB-shift-in receiver rebuilds each frame from the line.
module tb_handshake_transmitter;
  logic        clk;
  logic        rst_l;
  logic        send_start;
  logic [15:0] data_in;
  logic        serial_out;
  logic        send_done;
  logic        sending;

  int compared   = 0;
  int mismatched = 0;

  handshake_transmitter dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .send_start (send_start),
    .data_in    (data_in),
    .serial_out (serial_out),
    .send_done  (send_done),
    .sending    (sending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a frame and follows it to DONE, checking every line bit and the status outputs.
  task automatic applyStimulus(input string tag, input logic [15:0] data, input bit toggle);
    logic [23:0] expFrame;
    logic [23:0] rx;
    expFrame   = {8'hB4, data};
    rx         = '0;
    send_start = 1'b1;
    data_in    = data;
    tick();
    send_start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      checkOutput({tag, " bit"}, {31'd0, serial_out}, {31'd0, expFrame[23-i]});
      checkOutput({tag, " sending"}, {31'd0, sending}, 32'd1);
      checkOutput({tag, " done low"}, {31'd0, send_done}, 32'd0);
      rx = {rx[22:0], serial_out};
      if (toggle)
        data_in = ~data_in;
      tick();
    end
    checkOutput({tag, " done high"}, {31'd0, send_done}, 32'd1);
    checkOutput({tag, " line low"}, {31'd0, serial_out}, 32'd0);
    checkOutput({tag, " sending low"}, {31'd0, sending}, 32'd0);
    checkOutput({tag, " rx sync"}, {24'd0, rx[23:16]}, 32'h0000_00B4);
    checkOutput({tag, " rx data"}, {16'd0, rx[15:0]}, {16'd0, data});
  endtask

  // Watches an idle line: it must stay low and never present the sync pattern.
  task automatic idleWatch(input string tag, input int cycles);
    logic [7:0] window;
    window = '0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      window = {window[6:0], serial_out};
      checkOutput({tag, " line"}, {31'd0, serial_out}, 32'd0);
      checkOutput({tag, " no sync"}, {31'd0, (window == 8'hB4)}, 32'd0);
    end
  endtask

  initial begin
    rst_l      = 1'b0;
    send_start = 1'b0;
    data_in    = '0;
    #2;
    checkOutput("reset line", {31'd0, serial_out}, 32'd0);
    checkOutput("reset done", {31'd0, send_done}, 32'd0);
    checkOutput("reset sending", {31'd0, sending}, 32'd0);
    tick();
    rst_l = 1'b1;
    idleWatch("idle after reset", 100);
    checkOutput("idle sending", {31'd0, sending}, 32'd0);
    checkOutput("idle done", {31'd0, send_done}, 32'd0);

    applyStimulus("ones", 16'hFFFF, 1'b0);
    applyStimulus("alternating", 16'hAAAA, 1'b0);

    // Abort three cycles into DATA, then send zero data.
    send_start = 1'b1;
    data_in    = 16'hFFFF;
    tick();
    send_start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      checkOutput("pre-abort bit", {31'd0, serial_out}, {31'd0, (i < 8) ? 1'(8'hB4 >> (7 - i)) : 1'b1});
      tick();
    end
    applyStimulus("abort zero", 16'h0000, 1'b0);

    applyStimulus("restart from done", 16'h5A5A, 1'b0);
    applyStimulus("toggled input", 16'hC3A5, 1'b1);
    idleWatch("idle after done", 100);
    checkOutput("done holds", {31'd0, send_done}, 32'd1);

    // Reset pulsed mid-SYNC while the line carries a 1 (third sync bit).
    send_start = 1'b1;
    data_in    = 16'hFFFF;
    tick();
    send_start = 1'b0;
    tick();
    tick();
    checkOutput("pre-reset bit", {31'd0, serial_out}, 32'd1);
    #2;
    rst_l = 1'b0;
    #1;
    checkOutput("async reset line", {31'd0, serial_out}, 32'd0);
    checkOutput("async reset sending", {31'd0, sending}, 32'd0);
    checkOutput("async reset done", {31'd0, send_done}, 32'd0);
    tick();
    tick();
    rst_l = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tick();
      checkOutput("post-reset line", {31'd0, serial_out}, 32'd0);
      checkOutput("post-reset sending", {31'd0, sending}, 32'd0);
    end
    checkOutput("post-reset done", {31'd0, send_done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/handshake_transmitter.md
HANDSHAKE_TRANSMITTER -- requirements
Module: handshake_transmitter

Interface
REQ-001 The block SHALL have no parameters; SYNC_BITS, SYNCWORD and ENC_HEAD_BITS SHALL come from NetworkPkg.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port clk  input  1  GPIO clock, all state on rising edge.
REQ-004 Port rst_l  input  1  asynchronous active-low reset.
REQ-005 Port send_start  input  1  1-cycle pulse; capture data_in and begin a new transmission.
REQ-006 Port data_in  input  ENC_HEAD_BITS  encoded packet; sampled only in the send_start cycle.
REQ-007 Port serial_out  output  1  registered serial bit onto the handshake wire.
REQ-008 Port send_done  output  1  level; full frame sent, held until the next send_start.
REQ-009 Port sending  output  1  high while the frame's SYNC or DATA bits are on serial_out.

Function
REQ-010 The frame SHALL be SYNCWORD followed by data_in, both MSB first, so that a downstream LSB-shift-in receiver reconstructs data_in bit-exact.
REQ-011 The FSM SHALL have the states IDLE, SYNC, DATA and DONE.
REQ-012 In IDLE, send_start SHALL load {SYNCWORD, data_in} into a SYNC_BITS+ENC_HEAD_BITS frame register, clear the bit counter and enter SYNC.
REQ-013 serial_out SHALL present the first SYNCWORD MSB in the cycle after send_start (1-cycle latency), then 1 new bit per cycle.
REQ-014 SYNC SHALL last exactly SYNC_BITS cycles, then go to DATA.
REQ-015 DATA SHALL last exactly ENC_HEAD_BITS cycles, then go to DONE.
REQ-016 send_done SHALL rise in the cycle after the last data bit (SYNC_BITS+ENC_HEAD_BITS+1 cycles after send_start).
REQ-017 In DONE, send_done SHALL stay at 1 and serial_out at 0 until send_start.
REQ-018 In IDLE and DONE, serial_out SHALL be 0 so the idle line never forms SYNCWORD (SYNCWORD SHALL NOT be all-zero).
REQ-019 send_start in any state, including mid-SYNC or mid-DATA, SHALL abort the current frame, reload from data_in and restart at SYNC, with send_done cleared in the next cycle.
REQ-020 Changes on data_in outside the send_start cycle SHALL NOT affect the frame in flight.
REQ-021 The bit counter SHALL be 8 bits, SHALL reset at each state entry, and SHALL NOT wrap within a frame (SYNC_BITS, ENC_HEAD_BITS <= 255).
REQ-022 sending SHALL equal (state == SYNC || state == DATA).

Reset
REQ-023 On rst_l low the block SHALL immediately force state=IDLE, serial_out=0, send_done=0, sending=0, counter=0 and frame register=0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no further bits emitted.
REQ-025 After reset release, the block SHALL stay idle until send_start.

Structure
REQ-026 The state typedef tx_state_t {IDLE, SYNC, DATA, DONE} SHALL live in NetworkPkg, alongside SYNC_BITS, SYNCWORD and ENC_HEAD_BITS.
REQ-027 The frame register SHALL be the existing shift_reg sub-module (WIDTH = SYNC_BITS+ENC_HEAD_BITS, load on send_start, shift in 0), with serial_out registered from its MSB.
REQ-028 Bit counting SHALL reuse the existing counter sub-module (WIDTH 8).

Verification
REQ-029 Reset, then send_start with data_in=all-ones: serial_out = SYNCWORD MSB-first, then ENC_HEAD_BITS ones; send_done high at cycle SYNC_BITS+ENC_HEAD_BITS+1.
REQ-030 Loopback into HandshakeReceiver with receive_start and send_start in the same cycle, data_in=alternating 1010...: receive_done asserts and data_out == data_in.
REQ-031 send_start again 3 cycles into DATA with data_in=0: the frame restarts with SYNCWORD, the old bits are not completed, and the second frame is received as all-zero.
REQ-032 data_in toggled every cycle after send_start: the transmitted data equals the value captured at send_start.
REQ-033 rst_l pulsed low mid-SYNC: serial_out=0, send_done=0 and sending=0 asynchronously, and the line stays 0 for 2*(SYNC_BITS+ENC_HEAD_BITS) cycles.
REQ-034 Idle for 100 cycles after reset and after DONE: serial_out stays 0 and the receiver sync never fires.
